led_blink_coder: RTL and testbench

LED_BLINK_CODER -- requirements
Module: led_blink_coder

---
 rtl/led_blink_coder.sv | 167 ++++++++++++++++
 tb/tb_led_blink_coder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_coder.sv
// Displays a 4-bit code as repeating bursts of LED blinks with a dark gap between bursts.
// New codes are queued in a one-entry pending slot and take effect only at the end of a gap.
module led_blink_coder #(
   parameter int TICK_DIV  = 1000000,
   parameter int ON_TICKS  = 8,
   parameter int OFF_TICKS = 8,
   parameter int GAP_TICKS = 40,
   parameter int BRIGHT    = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] code_in,
   input  logic       code_valid,
   output logic       code_ready,
   output logic       busy,
   output logic [3:0] cur_code,
   output logic       LED,
   output logic [1:0] state_dbg
);

   // Handshake: a code transfers on any rising edge where code_valid and
   // code_ready are both high; code_in is sampled on that edge.

   localparam int PR_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ?
                           ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                           ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PR_W-1:0] PR_LAST  = PR_W'(TICK_DIV - 1);
   localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
   localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
   localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);
   localparam logic [5:0]      BRIGHT6  = 6'(BRIGHT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cur_code_q, cur_code_d;
   logic [3:0]      blink_q, blink_d;
   logic            pend_valid_q, pend_valid_d;
   logic [3:0]      pend_code_q, pend_code_d;
   logic [PR_W-1:0] presc_q, presc_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [4:0]      acc_q, acc_d;

   logic            hs;
   logic            tick;
   logic            phase_end;
   logic [PH_W-1:0] phase_last;
   logic [5:0]      sum;
   logic [3:0]      next_code;

   always_comb begin
      state_d      = state_q;
      cur_code_d   = cur_code_q;
      blink_d      = blink_q;
      pend_valid_d = pend_valid_q;
      pend_code_d  = pend_code_q;
      presc_d      = presc_q;
      phase_d      = phase_q;
      next_code    = cur_code_q;

      hs   = code_valid & ~pend_valid_q;
      tick = (presc_q == PR_LAST);

      case (state_q)
         ST_ON:   phase_last = ON_LAST;
         ST_OFF:  phase_last = OFF_LAST;
         default: phase_last = GAP_LAST;
      endcase
      phase_end = (state_q != ST_IDLE) && tick && (phase_q == phase_last);

      // First-order sigma-delta: the carry out is the PWM bit.
      sum   = {1'b0, acc_q} + BRIGHT6;
      acc_d = sum[4:0];

      if (state_q != ST_IDLE) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         phase_d = tick ? phase_q + 1'b1 : phase_q;
         if (hs && !(state_q == ST_GAP && phase_end)) begin
            pend_valid_d = 1'b1;
            pend_code_d  = code_in;
         end
      end
      if (phase_end) begin
         presc_d = '0;
         phase_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            phase_d = '0;
            if (hs) begin
               cur_code_d = code_in;
               if (code_in != 4'd0) begin
                  blink_d = 4'd1;
                  state_d = ST_ON;
               end
            end
         end
         ST_ON: begin
            if (phase_end) state_d = (blink_q < cur_code_q) ? ST_OFF : ST_GAP;
         end
         ST_OFF: begin
            if (phase_end) begin
               blink_d = blink_q + 4'd1;
               state_d = ST_ON;
            end
         end
         ST_GAP: begin
            if (phase_end) begin
               // Pending code wins; otherwise a same-cycle offer bypasses the slot.
               if (pend_valid_q) begin
                  next_code    = pend_code_q;
                  pend_valid_d = 1'b0;
               end else if (hs) begin
                  next_code = code_in;
               end
               cur_code_d = next_code;
               if (next_code == 4'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  blink_d = 4'd1;
                  state_d = ST_ON;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cur_code_q   <= 4'd0;
         blink_q      <= 4'd0;
         pend_valid_q <= 1'b0;
         pend_code_q  <= 4'd0;
         presc_q      <= '0;
         phase_q      <= '0;
         acc_q        <= 5'd0;
      end else begin
         state_q      <= state_d;
         cur_code_q   <= cur_code_d;
         blink_q      <= blink_d;
         pend_valid_q <= pend_valid_d;
         pend_code_q  <= pend_code_d;
         presc_q      <= presc_d;
         phase_q      <= phase_d;
         acc_q        <= acc_d;
      end
   end

   assign code_ready = ~pend_valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign cur_code   = cur_code_q;
   assign LED        = (state_q == ST_ON) & sum[5];
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_led_blink_coder.sv
// Directed bench for led_blink_coder: three instances share stimulus and differ only in BRIGHT,
// so the full-brightness instance carries the state/handshake checks and the others the PWM checks.
module tb_led_blink_coder;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] code_in = 4'd0;
   logic       code_valid = 1'b0;

   logic       code_ready, busy, led;
   logic [3:0] cur_code;
   logic [1:0] state_dbg;
   logic       ready16, busy16, led16, ready0, busy0, led0;
   logic [3:0] cur16, cur0;
   logic [1:0] st16, st0;

   int total = 0;
   int bad   = 0;

   logic [1:0] exp_q[$];
   int underrun, on_cnt, led16_cnt, led0_cnt, alt_err;
   logic [1:0] prev_e;
   logic       prev_led16;

   led_blink_coder #(.TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1), .GAP_TICKS(3), .BRIGHT(32)) u_dut (
      .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
      .code_ready(code_ready), .busy(busy), .cur_code(cur_code), .LED(led), .state_dbg(state_dbg));

   led_blink_coder #(.TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1), .GAP_TICKS(3), .BRIGHT(16)) u_dut16 (
      .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
      .code_ready(ready16), .busy(busy16), .cur_code(cur16), .LED(led16), .state_dbg(st16));

   led_blink_coder #(.TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1), .GAP_TICKS(3), .BRIGHT(0)) u_dut0 (
      .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
      .code_ready(ready0), .busy(busy0), .cur_code(cur0), .LED(led0), .state_dbg(st0));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_counts();
      on_cnt = 0; led16_cnt = 0; led0_cnt = 0; alt_err = 0;
      prev_e = S_IDLE; prev_led16 = 1'b0;
   endtask

   // One display period of a nonzero code: bursts separated by OFF, then the gap.
   task automatic push_period(input int code);
      for (int b = 1; b <= code; b++) begin
         repeat (8) exp_q.push_back(S_ON);
         if (b < code) repeat (4) exp_q.push_back(S_OFF);
      end
      repeat (12) exp_q.push_back(S_GAP);
   endtask

   task automatic run_cycles(input int n);
      logic [1:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else begin
            e = S_IDLE;
            underrun++;
         end
         chk("state", 32'(state_dbg), 32'(e));
         chk("led", 32'(led), 32'(e == S_ON));
         chk("busy", 32'(busy), 32'(e != S_IDLE));
         if (e == S_ON) begin
            on_cnt++;
            led16_cnt += int'(led16);
            led0_cnt  += int'(led0);
            if (prev_e == S_ON && led16 == prev_led16) alt_err++;
         end
         prev_e = e;
         prev_led16 = led16;
      end
   endtask

   task automatic drive_hs(input logic [3:0] code);
      code_in = code;
      code_valid = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      code_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      underrun = 0;
      clear_counts();
      chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
      chk("rst_busy", 32'(busy), 0);
      chk("rst_led", 32'(led), 0);
      chk("rst_ready", 32'(code_ready), 1);
      chk("rst_cur", 32'(cur_code), 0);
   endtask

   task automatic drained();
      chk("exp_q_left", 32'(exp_q.size()), 0);
      chk("exp_q_underrun", 32'(underrun), 0);
   endtask

   initial begin
      // Scenario 1: code 3 repeats, two full 44-cycle periods.
      do_reset();
      push_period(3);
      push_period(3);
      drive_hs(4'd3);
      run_cycles(1);
      code_valid = 1'b0;
      run_cycles(87);
      chk("s1_on_cycles", 32'(on_cnt), 48);
      chk("s1_led16_cnt", 32'(led16_cnt), 24);
      chk("s1_led16_alt", 32'(alt_err), 0);
      chk("s1_led0_cnt", 32'(led0_cnt), 0);
      chk("s1_cur", 32'(cur_code), 3);
      drained();

      // Scenario 2: code 1 offered during the second ON burst of code 3.
      do_reset();
      push_period(3);
      push_period(1);
      drive_hs(4'd3);
      run_cycles(1);
      code_valid = 1'b0;
      run_cycles(13);
      drive_hs(4'd1);
      run_cycles(1);
      code_valid = 1'b0;
      chk("s2_ready_drop", 32'(code_ready), 0);
      chk("s2_cur_hold", 32'(cur_code), 3);
      run_cycles(29);
      chk("s2_ready_gap", 32'(code_ready), 0);
      chk("s2_cur_gap", 32'(cur_code), 3);
      clear_counts();
      run_cycles(1);
      chk("s2_cur_new", 32'(cur_code), 1);
      chk("s2_ready_back", 32'(code_ready), 1);
      run_cycles(19);
      chk("s2_led16_cnt", 32'(led16_cnt), 4);
      chk("s2_led16_alt", 32'(alt_err), 0);
      chk("s2_led0_cnt", 32'(led0_cnt), 0);
      drained();

      // Scenario 3: code 0 during ON returns to IDLE after the gap.
      do_reset();
      push_period(3);
      repeat (3) exp_q.push_back(S_IDLE);
      drive_hs(4'd3);
      run_cycles(1);
      code_valid = 1'b0;
      run_cycles(2);
      drive_hs(4'd0);
      run_cycles(1);
      code_valid = 1'b0;
      chk("s3_ready_drop", 32'(code_ready), 0);
      run_cycles(43);
      chk("s3_cur", 32'(cur_code), 0);
      chk("s3_ready", 32'(code_ready), 1);
      chk("s3_busy", 32'(busy), 0);
      drained();

      // Scenario 4: code 2 offered on the final GAP cycle bypasses the pending slot.
      do_reset();
      push_period(1);
      push_period(2);
      drive_hs(4'd1);
      run_cycles(1);
      code_valid = 1'b0;
      run_cycles(19);
      drive_hs(4'd2);
      run_cycles(1);
      code_valid = 1'b0;
      chk("s4_cur", 32'(cur_code), 2);
      chk("s4_ready", 32'(code_ready), 1);
      run_cycles(31);
      chk("s4_cur_end", 32'(cur_code), 2);
      drained();

      // Scenario 6: reset mid-OFF with a pending code and a live offer.
      do_reset();
      push_period(3);
      drive_hs(4'd3);
      run_cycles(1);
      code_valid = 1'b0;
      run_cycles(2);
      drive_hs(4'd2);
      run_cycles(1);
      code_valid = 1'b0;
      chk("s6_ready_drop", 32'(code_ready), 0);
      run_cycles(6);
      chk("s6_in_off", 32'(state_dbg), 32'(S_OFF));
      exp_q.delete();
      reset = 1'b1;
      code_in = 4'd5;
      code_valid = 1'b1;
      @(negedge clk);
      chk("s6_state", 32'(state_dbg), 32'(S_IDLE));
      chk("s6_cur", 32'(cur_code), 0);
      chk("s6_ready", 32'(code_ready), 1);
      chk("s6_led", 32'(led), 0);
      chk("s6_busy", 32'(busy), 0);
      reset = 1'b0;
      code_valid = 1'b0;
      @(negedge clk);
      chk("s6_state_after", 32'(state_dbg), 32'(S_IDLE));
      chk("s6_cur_after", 32'(cur_code), 0);
      drained();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
